// File: rtl/uart_rx_fifo.sv
// UART receiver (configurable data/parity/stop) feeding a show-ahead FIFO with sticky error flags.
// Latency: byte at head 1 cycle after final stop sample; backpressure: none, a push into a full FIFO is dropped and flagged.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          iCE_CLK,
  input  logic                          RST_N,
  input  logic                          RX,
  output logic [DATA_BITS-1:0]          REC_BYTE,
  output logic                          RECEIVED,
  input  logic                          RD_EN,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
  output logic                          FRAME_ERR,
  output logic                          PARITY_ERR,
  output logic                          OVERRUN,
  input  logic                          CLR_ERR
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = 4;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [IW-1:0]        idx, idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 par_bad, par_bad_nxt;
  logic                 sync1, rx_s;
  logic                 push_nxt, push_q;
  logic [DATA_BITS-1:0] push_dat;
  logic                 ferr_set, perr_set;
  logic                 tick;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic [DATA_BITS-1:0] last_q;
  logic                 full, do_push, do_pop, ovr_set;

  assign tick = (cnt == '0);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    shreg_nxt   = shreg;
    par_bad_nxt = par_bad;
    push_nxt    = 1'b0;
    ferr_set    = 1'b0;
    perr_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_nxt = S_START;
          cnt_nxt   = HALF_BIT;
        end
      end
      S_START: begin
        if (!tick) begin
          cnt_nxt = cnt - 1'b1;
        end else if (rx_s) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt   = S_DATA;
          cnt_nxt     = FULL_BIT;
          idx_nxt     = '0;
          par_bad_nxt = 1'b0;
        end
      end
      S_DATA: begin
        if (!tick) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
          cnt_nxt   = FULL_BIT;
          if (idx == LAST_DATA) begin
            idx_nxt   = '0;
            state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (!tick) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          cnt_nxt   = FULL_BIT;
          state_nxt = S_STOP;
          // odd parity needs a total XOR of 1, even parity needs 0
          if ((^{shreg, rx_s}) != (PARITY == 1)) begin
            par_bad_nxt = 1'b1;
            perr_set    = 1'b1;
          end
        end
      end
      S_STOP: begin
        if (!tick) begin
          cnt_nxt = cnt - 1'b1;
        end else if (!rx_s) begin
          ferr_set  = 1'b1;
          state_nxt = S_BREAK;
        end else if (idx == LAST_STOP) begin
          state_nxt = S_IDLE;
          push_nxt  = !par_bad;
        end else begin
          idx_nxt = idx + 1'b1;
          cnt_nxt = FULL_BIT;
        end
      end
      S_BREAK: begin
        if (rx_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iCE_CLK) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      par_bad  <= 1'b0;
      sync1    <= 1'b1;
      rx_s     <= 1'b1;
      push_q   <= 1'b0;
      push_dat <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      shreg   <= shreg_nxt;
      par_bad <= par_bad_nxt;
      sync1   <= RX;
      rx_s    <= sync1;
      push_q  <= push_nxt;
      if (push_nxt) push_dat <= shreg;
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle
  assign full    = (count == DEPTH_C);
  assign do_pop  = RD_EN && (count != '0);
  assign do_push = push_q && (!full || do_pop);
  assign ovr_set = push_q && full && !do_pop;

  always_ff @(posedge iCE_CLK) begin
    if (do_push && RST_N) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge iCE_CLK) begin
    if (!RST_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_q     <= '0;
      FRAME_ERR  <= 1'b0;
      PARITY_ERR <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (count != '0) last_q <= mem[rd_ptr];
      FRAME_ERR  <= ferr_set | (FRAME_ERR  & ~CLR_ERR);
      PARITY_ERR <= perr_set | (PARITY_ERR & ~CLR_ERR);
      OVERRUN    <= ovr_set  | (OVERRUN    & ~CLR_ERR);
    end
  end

  assign RECEIVED   = (count != '0);
  assign FIFO_COUNT = count;
  assign REC_BYTE   = RECEIVED ? mem[rd_ptr] : last_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 instance and an even-parity instance on a shared line.
module tb_uart_rx_fifo;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       rd_en;
  logic       clr_err;

  logic [7:0] rec_byte_a, rec_byte_b;
  logic       received_a, received_b;
  logic [2:0] fifo_count_a, fifo_count_b;
  logic       frame_err_a, frame_err_b;
  logic       parity_err_a, parity_err_b;
  logic       overrun_a, overrun_b;

  int checks = 0;
  int errors = 0;
  int k;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .iCE_CLK(clk), .RST_N(rst_n), .RX(rx),
    .REC_BYTE(rec_byte_a), .RECEIVED(received_a), .RD_EN(rd_en),
    .FIFO_COUNT(fifo_count_a), .FRAME_ERR(frame_err_a), .PARITY_ERR(parity_err_a),
    .OVERRUN(overrun_a), .CLR_ERR(clr_err)
  );

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .iCE_CLK(clk), .RST_N(rst_n), .RX(rx),
    .REC_BYTE(rec_byte_b), .RECEIVED(received_b), .RD_EN(1'b0),
    .FIFO_COUNT(fifo_count_b), .FRAME_ERR(frame_err_b), .PARITY_ERR(parity_err_b),
    .OVERRUN(overrun_b), .CLR_ERR(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] f8n1(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  // bits[0] goes on the line first; each bit is held CPB cycles
  task automatic send(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rx = 1'b1; rst_n = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_received", received_a, 0);
    check("rst_count", fifo_count_a, 0);
    check("rst_byte", rec_byte_a, 0);
    check("rst_flags", {frame_err_a, parity_err_a, overrun_a}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: single 8N1 frame, exact arrival cycle
    k = 0;
    fork
      send(f8n1(8'hA5), 10);
      begin
        do begin
          @(negedge clk);
          k++;
        end while (!received_a && k < 300);
      end
    join
    check("t1_latency", k, 156);
    check("t1_byte", rec_byte_a, 8'hA5);
    check("t1_count", fifo_count_a, 1);
    check("t1_flags", {frame_err_a, parity_err_a, overrun_a}, 0);
    pop();
    check("t1_empty", received_a, 0);
    check("t1_hold", rec_byte_a, 8'hA5);

    // 2: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send(f8n1(8'(i)), 10);
    repeat (4) @(negedge clk);
    check("t2_count", fifo_count_a, 4);
    check("t2_overrun", overrun_a, 1);
    for (int i = 1; i <= 4; i++) begin
      check("t2_pop", rec_byte_a, i);
      pop();
    end
    check("t2_empty", received_a, 0);
    check("t2_frame", frame_err_a, 0);

    // 3: even parity instance
    do_reset();
    send({5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    repeat (4) @(negedge clk);
    check("t3_perr", parity_err_b, 1);
    check("t3_drop", received_b, 0);
    check("t3_ferr", frame_err_b, 0);
    send({5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    repeat (4) @(negedge clk);
    check("t3_good", received_b, 1);
    check("t3_byte", rec_byte_b, 8'h07);
    check("t3_count", fifo_count_b, 1);

    // 4: stop bit low followed by a long break
    do_reset();
    send({7'b0, 8'h55, 1'b0}, 9);
    rx = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    check("t4_ferr", frame_err_a, 1);
    check("t4_nobyte", received_a, 0);
    check("t4_count", fifo_count_a, 0);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send(f8n1(8'h3C), 10);
    repeat (4) @(negedge clk);
    check("t4_recv", received_a, 1);
    check("t4_byte", rec_byte_a, 8'h3C);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("t4_clr", frame_err_a, 0);

    // 5: glitch rejection, then reset in the middle of a frame
    do_reset();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("t5_glitch_flags", {frame_err_a, parity_err_a, overrun_a}, 0);
    check("t5_glitch_recv", received_a, 0);
    send(f8n1(8'h5A), 10);
    repeat (4) @(negedge clk);
    check("t5_after_glitch", rec_byte_a, 8'h5A);
    fork
      send(f8n1(8'hFF), 10);
      begin
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_recv", received_a, 0);
        check("t5_rst_count", fifo_count_a, 0);
        check("t5_rst_byte", rec_byte_a, 0);
        rst_n = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    check("t5_discard", received_a, 0);

    // 6: simultaneous push and pop on a full FIFO, then clear racing an error
    do_reset();
    send(f8n1(8'h11), 10);
    send(f8n1(8'h22), 10);
    send(f8n1(8'h33), 10);
    send(f8n1(8'h44), 10);
    check("t6_full", fifo_count_a, 4);
    fork
      send(f8n1(8'h55), 10);
      begin
        repeat (155) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    check("t6_count", fifo_count_a, 4);
    check("t6_no_ovr", overrun_a, 0);
    check("t6_head", rec_byte_a, 8'h22);
    fork
      send(f8n1(8'h66), 10);
      begin
        repeat (155) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
      end
    join
    check("t6_ovr_wins", overrun_a, 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("t6_ovr_clr", overrun_a, 0);
    for (int i = 2; i <= 5; i++) begin
      check("t6_pop", rec_byte_a, 8'h11 * i);
      pop();
    end
    check("t6_empty", received_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
